dvfs_controller: RTL

DVFS_CONTROLLER -- requirements
Module: dvfs_controller

---
 rtl/dvfs_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/dvfs_controller.sv
// Purpose: selects between clk_100 and the divided clock based on recent heavy-instruction density.
// Latency: a qualifying event at edge N enters a switch state at N+1; the destination state is reached at N+SETTLE+1.
// Backpressure: stall is held high for SETTLE cycles per switch; inputs are ignored while switching.
module dvfs_controller #(
  parameter int UP_THRESH   = 4,
  parameter int DOWN_THRESH = 16,
  parameter int SETTLE      = 8
) (
  input  logic       clk_100,
  input  logic       reset,
  input  logic       dvfs_en,
  input  logic       instr_valid,
  input  logic [2:0] opcode,
  output logic       fast_sel,
  output logic       stall,
  output logic [1:0] state,
  output logic [7:0] switch_count
);

  typedef enum logic [1:0] {
    SLOW    = 2'b00,
    SW_UP   = 2'b01,
    FAST    = 2'b10,
    SW_DOWN = 2'b11
  } state_t;

  localparam logic [7:0] UP_T      = 8'(UP_THRESH);
  localparam logic [7:0] DOWN_T    = 8'(DOWN_THRESH);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     cur;
  logic [7:0] up_cnt;
  logic [7:0] idle_cnt;
  logic [3:0] settle_cnt;
  logic       heavy;
  logic [7:0] count_sat_inc;

  // Heavy class only counts when the opcode is qualified by instr_valid.
  assign heavy = instr_valid && (opcode == 3'b100);

  // Switch counter saturates at 255 rather than wrapping.
  assign count_sat_inc = (switch_count == 8'hFF) ? 8'hFF : switch_count + 8'd1;

  // The state register itself drives the state output, so it stays registered.
  assign state = cur;

  // Single FSM: counters, settle timer and all outputs are registered together.
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      cur          <= SLOW;
      up_cnt       <= 8'd0;
      idle_cnt     <= 8'd0;
      settle_cnt   <= 4'd0;
      fast_sel     <= 1'b0;
      stall        <= 1'b0;
      switch_count <= 8'd0;
    end else begin
      case (cur)
        SLOW: begin
          // Disabling scaling forces the fast clock, so it also triggers the up switch.
          if (!dvfs_en || (heavy && (up_cnt + 8'd1 == UP_T))) begin
            cur          <= SW_UP;
            fast_sel     <= 1'b1;
            stall        <= 1'b1;
            up_cnt       <= 8'd0;
            settle_cnt   <= 4'd0;
            switch_count <= count_sat_inc;
          end else if (heavy) begin
            up_cnt <= up_cnt + 8'd1;
          end else if (instr_valid) begin
            up_cnt <= 8'd0;
          end
        end
        SW_UP: begin
          // Inputs are ignored; the handover always runs to completion.
          if (settle_cnt == SETTLE_M1) begin
            cur        <= FAST;
            stall      <= 1'b0;
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        FAST: begin
          if (!dvfs_en || heavy) begin
            idle_cnt <= 8'd0;
          end else if (idle_cnt + 8'd1 == DOWN_T) begin
            cur          <= SW_DOWN;
            fast_sel     <= 1'b0;
            stall        <= 1'b1;
            idle_cnt     <= 8'd0;
            settle_cnt   <= 4'd0;
            switch_count <= count_sat_inc;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        SW_DOWN: begin
          if (settle_cnt == SETTLE_M1) begin
            cur        <= SLOW;
            stall      <= 1'b0;
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: begin
          cur <= SLOW;
        end
      endcase
    end
  end

endmodule
